// File: rtl/pcie_rx_vc_router.sv
// Routes received TLPs into the VC0 or VC1 RX FIFO by Traffic Class and returns freed buffer space as FC credit updates.
// Latency: a TLP accepted in cycle N is written in cycle N+1 at the earliest. A credit update is presented one cycle after its VC becomes eligible.
// Backpressure: a full target FIFO holds the TLP in a one-entry register and drops tlp_ready_o. A low fc_upd_ready_i holds the update stable.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   tlp_valid_i, tlp_i, tlp_ready_o   224-bit TLP input with valid/ready (TC in tlp_i[214:212])
//   vcN_full, vcN_wren, vcN_wdata     write side of the VC0/VC1 receive FIFOs
//   vcN_rd_i                       consumer popped one entry from VC N (frees one credit)
//   fc_upd_valid_o, fc_upd_vc_o, fc_upd_credits_o, fc_upd_ready_i   credit update handshake
module pcie_rx_vc_router #(
    parameter logic [7:0] TC_VC1_MASK = 8'hFE,
    parameter int         UPD_THRESH  = 4,
    parameter int         UPD_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tlp_valid_i,
    input  logic [223:0] tlp_i,
    output logic         tlp_ready_o,
    input  logic         vc0_full,
    output logic         vc0_wren,
    output logic [223:0] vc0_wdata,
    input  logic         vc1_full,
    output logic         vc1_wren,
    output logic [223:0] vc1_wdata,
    input  logic         vc0_rd_i,
    input  logic         vc1_rd_i,
    output logic         fc_upd_valid_o,
    output logic         fc_upd_vc_o,
    output logic [7:0]   fc_upd_credits_o,
    input  logic         fc_upd_ready_i
);

    localparam int             TW       = $clog2(UPD_TIMEOUT);
    localparam logic [TW-1:0]  TMO_LAST = TW'(UPD_TIMEOUT - 1);
    localparam logic [7:0]     THRESH8  = 8'(UPD_THRESH);

    typedef enum logic {IDLE, SEND} state_t;

    // ------------------------------------------------------------------
    // Hold stage
    // ------------------------------------------------------------------
    logic         rst_done;     // keeps tlp_ready_o low until the first edge after reset release
    logic         hold_valid;
    logic [223:0] hold_data;
    logic         hold_vc;
    logic         hold_full;
    logic         accept;
    logic [2:0]   tc;

    assign tc          = tlp_i[214:212];
    assign hold_full   = hold_vc ? vc1_full : vc0_full;
    assign tlp_ready_o = rst_done && (!hold_valid || !hold_full);
    assign accept      = tlp_valid_i && tlp_ready_o;

    assign vc0_wren  = hold_valid && !hold_vc && !vc0_full;
    assign vc1_wren  = hold_valid &&  hold_vc && !vc1_full;
    assign vc0_wdata = hold_data;
    assign vc1_wdata = hold_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done   <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_vc    <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            // A new TLP may load in the same cycle the old entry drains.
            if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= tlp_i;
                hold_vc    <= TC_VC1_MASK[tc];
            end else if (vc0_wren || vc1_wren) begin
                hold_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Credit return
    // ------------------------------------------------------------------
    state_t        state, state_nxt;
    logic [7:0]    free0, free0_nxt;
    logic [7:0]    free1, free1_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          last_vc, last_vc_nxt;
    logic          upd_vc, upd_vc_nxt;
    logic [7:0]    upd_amt, upd_amt_nxt;
    logic          any_free, timeout, elig0, elig1, sel;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

    assign any_free = (free0 != 8'd0) || (free1 != 8'd0);
    assign timeout  = (timer == TMO_LAST);
    assign elig0    = (free0 >= THRESH8) || (timeout && (free0 != 8'd0));
    assign elig1    = (free1 >= THRESH8) || (timeout && (free1 != 8'd0));

    assign fc_upd_valid_o   = (state == SEND);
    assign fc_upd_vc_o      = upd_vc;
    assign fc_upd_credits_o = upd_amt;

    always_comb begin
        state_nxt   = state;
        free0_nxt   = sat_inc(free0, vc0_rd_i);
        free1_nxt   = sat_inc(free1, vc1_rd_i);
        timer_nxt   = timer;
        last_vc_nxt = last_vc;
        upd_vc_nxt  = upd_vc;
        upd_amt_nxt = upd_amt;
        sel         = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 || elig1) begin
                    // Round-robin only matters when both VCs are eligible.
                    sel         = (elig0 && elig1) ? !last_vc : elig1;
                    state_nxt   = SEND;
                    timer_nxt   = '0;
                    upd_vc_nxt  = sel;
                    upd_amt_nxt = sel ? free1 : free0;
                end else if (any_free) begin
                    timer_nxt = timer + 1'b1;
                end else begin
                    timer_nxt = '0;
                end
            end
            SEND: begin
                timer_nxt = '0;
                if (fc_upd_ready_i) begin
                    state_nxt   = IDLE;
                    last_vc_nxt = upd_vc;
                    // Subtract only what was advertised; pops seen meanwhile stay counted.
                    if (upd_vc) begin
                        free1_nxt = free1 - upd_amt + {7'd0, vc1_rd_i};
                    end else begin
                        free0_nxt = free0 - upd_amt + {7'd0, vc0_rd_i};
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            free0   <= 8'd0;
            free1   <= 8'd0;
            timer   <= '0;
            last_vc <= 1'b1;
            upd_vc  <= 1'b0;
            upd_amt <= 8'd0;
        end else begin
            state   <= state_nxt;
            free0   <= free0_nxt;
            free1   <= free1_nxt;
            timer   <= timer_nxt;
            last_vc <= last_vc_nxt;
            upd_vc  <= upd_vc_nxt;
            upd_amt <= upd_amt_nxt;
        end
    end

endmodule

// File: tb/tb_pcie_rx_vc_router.sv
// Directed bench for pcie_rx_vc_router: TC steering, throughput, stall, credit updates, round-robin, mid-run reset.
module tb_pcie_rx_vc_router;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tlp_valid_i;
    logic [223:0] tlp_i;
    logic         tlp_ready_o;
    logic         vc0_full, vc0_wren;
    logic [223:0] vc0_wdata;
    logic         vc1_full, vc1_wren;
    logic [223:0] vc1_wdata;
    logic         vc0_rd_i, vc1_rd_i;
    logic         fc_upd_valid_o, fc_upd_vc_o;
    logic [7:0]   fc_upd_credits_o;
    logic         fc_upd_ready_i;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pcie_rx_vc_router #(
        .TC_VC1_MASK (8'hFE),
        .UPD_THRESH  (4),
        .UPD_TIMEOUT (64)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tlp_valid_i      (tlp_valid_i),
        .tlp_i            (tlp_i),
        .tlp_ready_o      (tlp_ready_o),
        .vc0_full         (vc0_full),
        .vc0_wren         (vc0_wren),
        .vc0_wdata        (vc0_wdata),
        .vc1_full         (vc1_full),
        .vc1_wren         (vc1_wren),
        .vc1_wdata        (vc1_wdata),
        .vc0_rd_i         (vc0_rd_i),
        .vc1_rd_i         (vc1_rd_i),
        .fc_upd_valid_o   (fc_upd_valid_o),
        .fc_upd_vc_o      (fc_upd_vc_o),
        .fc_upd_credits_o (fc_upd_credits_o),
        .fc_upd_ready_i   (fc_upd_ready_i)
    );

    task automatic chk(input string tag, input logic [223:0] obs, input logic [223:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [223:0] mk_tlp(input logic [2:0] tc, input logic [31:0] seed);
        logic [223:0] t;
        t = {7{seed}};
        t[214:212] = tc;
        return t;
    endfunction

    // Expect exactly one write, to vc, carrying d.
    task automatic exp_wr(input string tag, input int vc, input logic [223:0] d);
        if (vc == 0) begin
            chk({tag, "_wren0"}, vc0_wren, 1);
            chk({tag, "_wdata0"}, vc0_wdata, d);
            chk({tag, "_wren1"}, vc1_wren, 0);
        end else begin
            chk({tag, "_wren1"}, vc1_wren, 1);
            chk({tag, "_wdata1"}, vc1_wdata, d);
            chk({tag, "_wren0"}, vc0_wren, 0);
        end
    endtask

    task automatic exp_upd(input string tag, input logic vc, input logic [7:0] cr);
        chk({tag, "_valid"}, fc_upd_valid_o, 1);
        chk({tag, "_vc"}, fc_upd_vc_o, vc);
        chk({tag, "_credits"}, fc_upd_credits_o, cr);
    endtask

    logic [223:0] t0, t1, t2, tx, tr;
    logic [223:0] seq[8];

    initial begin
        rst_n = 1'b1;
        tlp_valid_i = 0; tlp_i = '0;
        vc0_full = 0; vc1_full = 0;
        vc0_rd_i = 0; vc1_rd_i = 0;
        fc_upd_ready_i = 0;
        #1 rst_n = 1'b0;
        #1;
        // ---- reset state
        chk("rst_ready", tlp_ready_o, 0);
        chk("rst_wren0", vc0_wren, 0);
        chk("rst_wren1", vc1_wren, 0);
        chk("rst_wdata0", vc0_wdata, '0);
        chk("rst_updv", fc_upd_valid_o, 0);
        chk("rst_updvc", fc_upd_vc_o, 0);
        chk("rst_updcr", fc_upd_credits_o, 0);
        #20 rst_n = 1'b1;
        tick;
        chk("post_rst_ready", tlp_ready_o, 1);
        chk("post_rst_updv", fc_upd_valid_o, 0);

        // ---- single TC0 then TC3
        t0 = mk_tlp(3'd0, 32'h1111_0001);
        t1 = mk_tlp(3'd3, 32'h2222_0002);
        tlp_valid_i = 1; tlp_i = t0;
        #1 chk("t0_same_cycle", vc0_wren, 0);
        tick;
        exp_wr("tc0", 0, t0);
        tlp_i = t1;
        tick;
        exp_wr("tc3", 1, t1);
        tlp_valid_i = 0;
        tick;
        chk("idle_wren0", vc0_wren, 0);
        chk("idle_wren1", vc1_wren, 0);

        // ---- 8 back-to-back, alternating TC0 / TC5
        for (int i = 0; i < 8; i++) begin
            seq[i] = mk_tlp((i % 2 == 0) ? 3'd0 : 3'd5, 32'h3000_0000 + 32'h0101_0101 * i);
            tlp_valid_i = 1; tlp_i = seq[i];
            #1 chk("b2b_ready", tlp_ready_o, 1);
            if (i > 0) exp_wr("b2b", (i % 2 == 1) ? 0 : 1, seq[i-1]);
            tick;
        end
        tlp_valid_i = 0;
        exp_wr("b2b_last", 1, seq[7]);
        tick;

        // ---- stall on vc1_full with TC2; a TC0 TLP waits behind it
        t2 = mk_tlp(3'd2, 32'h4444_0004);
        tx = mk_tlp(3'd0, 32'h5555_0005);
        vc1_full = 1; tlp_valid_i = 1; tlp_i = t2;
        #1 chk("stall_ready_pre", tlp_ready_o, 1);
        tick;
        tlp_i = tx;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("stall_ready", tlp_ready_o, 0);
            chk("stall_wren1", vc1_wren, 0);
            chk("stall_wren0", vc0_wren, 0);
            chk("stall_data", vc1_wdata, t2);
            tick;
        end
        vc1_full = 0;
        #1;
        exp_wr("release", 1, t2);
        chk("release_ready", tlp_ready_o, 1);
        tick;
        tlp_valid_i = 0;
        exp_wr("follow", 0, tx);
        tick;
        chk("after_wren0", vc0_wren, 0);
        chk("after_wren1", vc1_wren, 0);

        // ---- credit update by threshold, held by ready=0
        vc0_rd_i = 1;
        repeat (4) tick;
        vc0_rd_i = 0;
        chk("thr_not_yet", fc_upd_valid_o, 0);
        tick;
        exp_upd("thr", 1'b0, 8'd4);
        for (int k = 0; k < 5; k++) begin
            vc0_rd_i = (k == 0 || k == 2);
            tick;
            exp_upd("held", 1'b0, 8'd4);
        end
        vc0_rd_i = 0;
        fc_upd_ready_i = 1;
        tick;
        fc_upd_ready_i = 0;
        chk("hs_drop", fc_upd_valid_o, 0);
        // 2 leftover credits go out only after the 64-cycle timeout
        for (int k = 1; k < 64; k++) begin
            tick;
            chk("tmo_wait", fc_upd_valid_o, 0);
        end
        tick;
        exp_upd("tmo", 1'b0, 8'd2);
        fc_upd_ready_i = 1;
        tick;
        fc_upd_ready_i = 0;
        chk("tmo_hs_drop", fc_upd_valid_o, 0);

        // ---- round-robin: build free0=5, free1=6 with last_vc=1
        vc1_rd_i = 1;
        repeat (4) tick;
        vc1_rd_i = 0;
        tick;
        exp_upd("rr_pre", 1'b1, 8'd4);
        for (int k = 0; k < 6; k++) begin
            vc0_rd_i = (k < 5);
            vc1_rd_i = 1;
            tick;
        end
        vc0_rd_i = 0; vc1_rd_i = 0;
        exp_upd("rr_pre_held", 1'b1, 8'd4);
        fc_upd_ready_i = 1;
        tick;
        fc_upd_ready_i = 0;
        chk("rr_gap1", fc_upd_valid_o, 0);
        tick;
        exp_upd("rr_first", 1'b0, 8'd5);
        fc_upd_ready_i = 1;
        tick;
        fc_upd_ready_i = 0;
        chk("rr_gap2", fc_upd_valid_o, 0);
        tick;
        exp_upd("rr_second", 1'b1, 8'd6);
        fc_upd_ready_i = 1;
        tick;
        fc_upd_ready_i = 0;
        chk("rr_done", fc_upd_valid_o, 0);

        // ---- mid-operation reset with a held TLP and a pending update
        tr = mk_tlp(3'd0, 32'h6666_0006);
        vc0_full = 1; tlp_valid_i = 1; tlp_i = tr; vc1_rd_i = 1;
        tick;
        tlp_valid_i = 0;
        repeat (3) tick;
        vc1_rd_i = 0;
        tick;
        exp_upd("mr_pending", 1'b1, 8'd4);
        chk("mr_held_ready", tlp_ready_o, 0);
        chk("mr_held_data", vc0_wdata, tr);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_ready", tlp_ready_o, 0);
        chk("mr_wren0", vc0_wren, 0);
        chk("mr_wdata0", vc0_wdata, '0);
        chk("mr_updv", fc_upd_valid_o, 0);
        chk("mr_updvc", fc_upd_vc_o, 0);
        chk("mr_updcr", fc_upd_credits_o, 0);
        vc0_full = 0;
        #3 rst_n = 1'b1;
        tick;
        chk("mr_post_ready", tlp_ready_o, 1);
        chk("mr_post_wren0", vc0_wren, 0);
        for (int k = 0; k < 70; k++) begin
            chk("mr_no_credit", fc_upd_valid_o, 0);
            tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
